// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation codes, MIPS opcode/funct constants and the decoded
// control record shared by alu_con_decode and id_ex_stage.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_MULT = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_DIV  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;

    typedef struct packed {
        logic [3:0] alu_con;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       use_rs;
        logic       use_rt;
        logic       imm_zext;
        logic       shift;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{alu_con: ALU_ADD, reg_write: 1'b0, mem_read: 1'b0,
                                   mem_write: 1'b0, use_rs: 1'b0, use_rt: 1'b0,
                                   imm_zext: 1'b0, shift: 1'b0};

endpackage

// File: rtl/alu_con_decode.sv
// alu_con_decode: combinational MIPS opcode/funct decode into the ALU
// operation code, downstream control and operand-source flags.
module alu_con_decode
    import alu_pkg::*;
(
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl,
    output logic        o_illegal
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic       w_unused;

    assign w_opcode = i_instr[31:26];
    assign w_funct  = i_instr[5:0];
    assign w_unused = ^i_instr[25:6];

    always_comb begin
        o_ctrl    = CTRL_NOP;
        o_illegal = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.use_rs    = 1'b1;
                o_ctrl.use_rt    = 1'b1;
                case (w_funct)
                    FN_AND:  o_ctrl.alu_con = ALU_AND;
                    FN_OR:   o_ctrl.alu_con = ALU_OR;
                    FN_ADD:  o_ctrl.alu_con = ALU_ADD;
                    FN_MULT: o_ctrl.alu_con = ALU_MULT;
                    FN_NOR:  o_ctrl.alu_con = ALU_NOR;
                    FN_DIV:  o_ctrl.alu_con = ALU_DIV;
                    FN_SUB:  o_ctrl.alu_con = ALU_SUB;
                    FN_SLT:  o_ctrl.alu_con = ALU_SLT;
                    // shifts take their operand from rt, rs is not read
                    FN_SLL: begin
                        o_ctrl.alu_con = ALU_SLL;
                        o_ctrl.shift   = 1'b1;
                        o_ctrl.use_rs  = 1'b0;
                    end
                    FN_SRL: begin
                        o_ctrl.alu_con = ALU_SRL;
                        o_ctrl.shift   = 1'b1;
                        o_ctrl.use_rs  = 1'b0;
                    end
                    default: begin
                        o_ctrl    = CTRL_NOP;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.use_rs    = 1'b1;
            end
            OP_SW: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.use_rs    = 1'b1;
                o_ctrl.use_rt    = 1'b1;
            end
            OP_ADDI: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.use_rs    = 1'b1;
            end
            OP_SLTI: begin
                o_ctrl.alu_con   = ALU_SLT;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.use_rs    = 1'b1;
            end
            OP_ANDI: begin
                o_ctrl.alu_con   = ALU_AND;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.use_rs    = 1'b1;
                o_ctrl.imm_zext  = 1'b1;
            end
            OP_ORI: begin
                o_ctrl.alu_con   = ALU_OR;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.use_rs    = 1'b1;
                o_ctrl.imm_zext  = 1'b1;
            end
            OP_BEQ: begin
                o_ctrl.alu_con = ALU_SUB;
                o_ctrl.use_rs  = 1'b1;
                o_ctrl.use_rt  = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode/issue register feeding the ALU, with hazard handling.
// FORWARDING_EN selects ALU/MEM forwarding; otherwise every RAW hazard stalls.
module id_ex_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       Instr,
    input  logic [DATA_W-1:0] RsData,
    input  logic [DATA_W-1:0] RtData,
    input  logic              Flush,
    input  logic [DATA_W-1:0] AluResult,
    input  logic              MemFwdWe,
    input  logic [4:0]        MemFwdRd,
    input  logic [DATA_W-1:0] MemFwdData,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        ALUCon,
    output logic [DATA_W-1:0] DataA,
    output logic [DATA_W-1:0] DataB,
    output logic [DATA_W-1:0] StoreData,
    output logic [4:0]        DestReg,
    output logic              RegWrite,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              IllegalInstr
);

    function automatic logic [DATA_W-1:0] ext_imm(input logic [15:0] imm, input logic zext);
        logic signed [15:0] s_imm;
        s_imm = imm;
        return zext ? {{(DATA_W-16){1'b0}}, imm} : {{(DATA_W-16){s_imm[15]}}, s_imm};
    endfunction

    ctrl_t             w_ctrl;
    logic              w_illegal;
    logic [4:0]        w_rs, w_rt, w_rd, w_dest;
    logic              w_is_rtype, w_is_beq;
    logic              w_rs_hit, w_rt_hit, w_held_wr, w_stall, w_capture;
    logic [DATA_W-1:0] w_rs_val, w_rt_val, w_data_a, w_data_b;

    logic              r_vld_p1, r_illegal_p1;
    logic [3:0]        r_alucon_p1;
    logic [DATA_W-1:0] r_data_a_p1, r_data_b_p1, r_store_p1;
    logic [4:0]        r_dest_p1;
    logic              r_regwr_p1, r_memrd_p1, r_memwr_p1;

    alu_con_decode u_decode (
        .i_instr   (Instr),
        .o_ctrl    (w_ctrl),
        .o_illegal (w_illegal)
    );

    assign w_rs       = Instr[25:21];
    assign w_rt       = Instr[20:16];
    assign w_rd       = Instr[15:11];
    assign w_is_rtype = (Instr[31:26] == OP_RTYPE);
    assign w_is_beq   = (Instr[31:26] == OP_BEQ);

    // a source "hits" the held instruction only if it is actually read and is not $0
    assign w_rs_hit  = w_ctrl.use_rs & (w_rs != 5'd0) & (w_rs == r_dest_p1);
    assign w_rt_hit  = w_ctrl.use_rt & (w_rt != 5'd0) & (w_rt == r_dest_p1);
    assign w_held_wr = r_vld_p1 & r_regwr_p1;

`ifdef FORWARDING_EN
    always_comb begin
        w_rs_val = RsData;
        if ((w_rs != 5'd0) && w_held_wr && !r_memrd_p1 && (r_dest_p1 == w_rs))
            w_rs_val = AluResult;
        else if ((w_rs != 5'd0) && MemFwdWe && (MemFwdRd == w_rs))
            w_rs_val = MemFwdData;
        w_rt_val = RtData;
        if ((w_rt != 5'd0) && w_held_wr && !r_memrd_p1 && (r_dest_p1 == w_rt))
            w_rt_val = AluResult;
        else if ((w_rt != 5'd0) && MemFwdWe && (MemFwdRd == w_rt))
            w_rt_val = MemFwdData;
    end

    assign w_stall = r_vld_p1 & r_memrd_p1 & (w_rs_hit | w_rt_hit);
`else
    logic w_mem_rs_hit, w_mem_rt_hit, w_unused_fwd;

    assign w_rs_val     = RsData;
    assign w_rt_val     = RtData;
    assign w_mem_rs_hit = MemFwdWe & w_ctrl.use_rs & (w_rs != 5'd0) & (MemFwdRd == w_rs);
    assign w_mem_rt_hit = MemFwdWe & w_ctrl.use_rt & (w_rt != 5'd0) & (MemFwdRd == w_rt);
    assign w_stall      = (w_held_wr & (w_rs_hit | w_rt_hit)) | w_mem_rs_hit | w_mem_rt_hit;
    assign w_unused_fwd = ^{AluResult, MemFwdData};
`endif

    always_comb begin
        w_data_a = w_ctrl.shift ? w_rt_val : w_rs_val;
        if (w_ctrl.shift)
            w_data_b = {{(DATA_W-5){1'b0}}, Instr[10:6]};
        else if (w_is_rtype || w_is_beq)
            w_data_b = w_rt_val;
        else
            w_data_b = ext_imm(Instr[15:0], w_ctrl.imm_zext);
        w_dest = w_illegal ? 5'd0 : (w_is_rtype ? w_rd : w_rt);
    end

    assign in_ready  = (!r_vld_p1 || out_ready) && !w_stall;
    assign w_capture = in_valid & in_ready;

    // ---- stage boundary: ID -> EX register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1     <= 1'b0;
            r_illegal_p1 <= 1'b0;
            r_alucon_p1  <= 4'd0;
            r_data_a_p1  <= '0;
            r_data_b_p1  <= '0;
            r_store_p1   <= '0;
            r_dest_p1    <= 5'd0;
            r_regwr_p1   <= 1'b0;
            r_memrd_p1   <= 1'b0;
            r_memwr_p1   <= 1'b0;
        end else if (Flush) begin
            r_vld_p1     <= 1'b0;
            r_illegal_p1 <= 1'b0;
        end else if (w_capture) begin
            r_vld_p1     <= 1'b1;
            r_illegal_p1 <= w_illegal;
            r_alucon_p1  <= w_ctrl.alu_con;
            r_data_a_p1  <= w_data_a;
            r_data_b_p1  <= w_data_b;
            r_store_p1   <= w_rt_val;
            r_dest_p1    <= w_dest;
            r_regwr_p1   <= w_ctrl.reg_write;
            r_memrd_p1   <= w_ctrl.mem_read;
            r_memwr_p1   <= w_ctrl.mem_write;
        end else begin
            r_illegal_p1 <= 1'b0;
            if (out_ready)
                r_vld_p1 <= 1'b0;
        end
    end

    assign out_valid    = r_vld_p1;
    assign IllegalInstr = r_illegal_p1;
    assign ALUCon       = r_alucon_p1;
    assign DataA        = r_data_a_p1;
    assign DataB        = r_data_b_p1;
    assign StoreData    = r_store_p1;
    assign DestReg      = r_dest_p1;
    assign RegWrite     = r_regwr_p1;
    assign MemRead      = r_memrd_p1;
    assign MemWrite     = r_memwr_p1;

endmodule
